// File: rtl/memo_recorder.sv
// Sample recorder: streams accepted samples into memory after a two-word
// header slot at addrBase, then back-fills the header with first/final data addresses.
module memo_recorder #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] sampleIn,
    input  logic              sampleValid,
    input  logic [ADDR_W-1:0] addrBase,
    input  logic [ADDR_W-1:0] addrLimit,
    output logic              writeEn,
    output logic [ADDR_W-1:0] addrOut,
    output logic [DATA_W-1:0] dataOut,
    output logic              ready,
    output logic              recording,
    output logic              done,
    output logic              full
);

    typedef enum logic [2:0] {
        IDLE,
        REC,
        WRITE,
        HDR0,
        HDR1,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    state_t            state;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] lim_reg;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] last_addr;
    logic              stop_pending;

    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] final_slot;
    logic              at_limit;

    assign start_ptr  = addrBase + TWO;
    assign first_addr = base_reg + TWO;
    assign final_slot = base_reg + ONE;
    assign at_limit   = (wr_ptr == lim_reg);

    // Outputs are registered: each transition loads the values that the
    // destination state presents, so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            base_reg     <= '0;
            lim_reg      <= '0;
            wr_ptr       <= '0;
            last_addr    <= '0;
            stop_pending <= 1'b0;
            writeEn      <= 1'b0;
            addrOut      <= '0;
            dataOut      <= '0;
            ready        <= 1'b0;
            recording    <= 1'b0;
            done         <= 1'b0;
            full         <= 1'b0;
        end else begin
            writeEn <= 1'b0;
            addrOut <= '0;
            dataOut <= '0;
            ready   <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg     <= addrBase;
                        lim_reg      <= addrLimit;
                        wr_ptr       <= start_ptr;
                        last_addr    <= addrBase + ONE;
                        stop_pending <= 1'b0;
                        recording    <= 1'b1;
                        // No room for even one sample: go straight to the header.
                        if (addrLimit < start_ptr) begin
                            full    <= 1'b1;
                            state   <= HDR0;
                            writeEn <= 1'b1;
                            addrOut <= addrBase;
                            dataOut <= DATA_W'(start_ptr);
                        end else begin
                            full  <= 1'b0;
                            state <= REC;
                            ready <= 1'b1;
                        end
                    end
                end

                REC: begin
                    if (sampleValid) begin
                        state   <= WRITE;
                        writeEn <= 1'b1;
                        addrOut <= wr_ptr;
                        dataOut <= sampleIn;
                        if (stop) stop_pending <= 1'b1;
                    end else if (stop || stop_pending) begin
                        state   <= HDR0;
                        writeEn <= 1'b1;
                        addrOut <= base_reg;
                        dataOut <= DATA_W'(first_addr);
                    end else begin
                        ready <= 1'b1;
                    end
                end

                WRITE: begin
                    last_addr <= wr_ptr;
                    if (!at_limit) wr_ptr <= wr_ptr + ONE;
                    if (stop) stop_pending <= 1'b1;
                    if (at_limit || stop_pending || stop) begin
                        if (at_limit) full <= 1'b1;
                        state   <= HDR0;
                        writeEn <= 1'b1;
                        addrOut <= base_reg;
                        dataOut <= DATA_W'(first_addr);
                    end else begin
                        state <= REC;
                        ready <= 1'b1;
                    end
                end

                HDR0: begin
                    state   <= HDR1;
                    writeEn <= 1'b1;
                    addrOut <= final_slot;
                    dataOut <= DATA_W'(last_addr);
                end

                HDR1: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    recording <= 1'b0;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memo_recorder.sv
// Bench for memo_recorder: table of directed recordings, a reset-abort sequence,
// and randomized recordings checked against a capacity-based expectation.
module tb_memo_recorder;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic [15:0] addrBase;
    logic [15:0] addrLimit;
    logic        writeEn;
    logic [15:0] addrOut;
    logic [15:0] dataOut;
    logic        ready;
    logic        recording;
    logic        done;
    logic        full;

    memo_recorder #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .sampleIn(sampleIn), .sampleValid(sampleValid),
        .addrBase(addrBase), .addrLimit(addrLimit),
        .writeEn(writeEn), .addrOut(addrOut), .dataOut(dataOut),
        .ready(ready), .recording(recording), .done(done), .full(full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_q[$];
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Write/done logger and idle-bus rule, sampled mid-cycle.
    always @(negedge clock) begin
        if (writeEn) wr_q.push_back({addrOut, dataOut});
        if (done) done_cnt++;
        if (!writeEn) chk("idle_bus", {addrOut, dataOut}, 32'h0);
    end

    function automatic logic [15:0] pat(input logic [15:0] seed, input int i);
        return 16'(seed + 16'(i) * 16'h1111);
    endfunction

    task automatic run_rec(input logic [15:0] b, input logic [15:0] l, input logic [15:0] seed,
                           input int n, input bit same_stop, input bit gaps,
                           input int exp_n, input logic [15:0] exp_final, input bit exp_full);
        int wr0, dn0, idx, cyc;
        bit stop_sent, x, prev_x;
        logic [15:0] acc[$];
        wr0 = wr_q.size();
        dn0 = done_cnt;
        idx = 0; cyc = 0; stop_sent = 0; prev_x = 0;
        @(negedge clock);
        addrBase = b; addrLimit = l; start = 1; sampleValid = 0; stop = 0;
        @(negedge clock);
        // stray start with a different window while recording must be ignored
        start = 1; addrBase = 16'(b + 16'h0400); addrLimit = 16'hFFFF;
        while (done_cnt == dn0 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            start = 0;
            if (prev_x) chk("ready_after_xfer", 32'(ready), 32'h0);
            if (idx < n) begin
                sampleValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                sampleIn    = pat(seed, idx);
            end else begin
                sampleValid = 1'b0;
            end
            x = sampleValid && ready;
            stop = 1'b0;
            if (same_stop && x && idx == n - 1) stop = 1'b1;
            else if (idx >= n && !stop_sent) stop = 1'b1;
            if (stop) stop_sent = 1;
            if (x) begin
                acc.push_back(sampleIn);
                idx++;
            end
            prev_x = x;
        end
        sampleValid = 0; stop = 0;
        chk("done_seen", 32'(done_cnt > dn0), 32'h1);
        repeat (3) @(negedge clock);
        chk("done_pulses", 32'(done_cnt - dn0), 32'h1);
        chk("accepted", 32'(acc.size()), 32'(exp_n));
        chk("write_count", 32'(wr_q.size() - wr0), 32'(exp_n + 2));
        if (wr_q.size() - wr0 == exp_n + 2) begin
            for (int i = 0; i < exp_n; i++)
                chk("data_write", wr_q[wr0 + i], {16'(b + 16'd2 + 16'(i)), pat(seed, i)});
            chk("hdr0", wr_q[wr0 + exp_n], {b, 16'(b + 16'd2)});
            chk("hdr1", wr_q[wr0 + exp_n + 1], {16'(b + 16'd1), exp_final});
        end
        chk("full", 32'(full), 32'(exp_full));
        chk("recording_end", 32'(recording), 32'h0);
    endtask

    typedef struct {
        logic [15:0] b;
        logic [15:0] l;
        logic [15:0] seed;
        int          n;
        bit          same_stop;
        bit          gaps;
        int          exp_n;
        logic [15:0] exp_final;
        bit          exp_full;
    } vec_t;

    vec_t vt[7];

    initial begin
        int wr0, dn0;
        vt[0] = '{16'h0100, 16'h01FF, 16'hAAAA, 3, 1'b0, 1'b0, 3, 16'h0104, 1'b0};
        vt[1] = '{16'h0010, 16'h0013, 16'h1000, 5, 1'b0, 1'b0, 2, 16'h0013, 1'b1};
        vt[2] = '{16'h0040, 16'h01FF, 16'h0000, 0, 1'b0, 1'b0, 0, 16'h0041, 1'b0};
        vt[3] = '{16'h0000, 16'h00FF, 16'h1234, 1, 1'b1, 1'b0, 1, 16'h0002, 1'b0};
        vt[4] = '{16'h0050, 16'h0051, 16'h0000, 2, 1'b0, 1'b0, 0, 16'h0051, 1'b1};
        vt[5] = '{16'h0200, 16'h0202, 16'h4321, 3, 1'b0, 1'b0, 1, 16'h0202, 1'b1};
        vt[6] = '{16'h0400, 16'h0410, 16'h9000, 4, 1'b0, 1'b1, 4, 16'h0405, 1'b0};

        reset = 1; start = 0; stop = 0; sampleIn = 0; sampleValid = 0;
        addrBase = 0; addrLimit = 0;
        repeat (3) @(negedge clock);
        chk("rst_writeEn", 32'(writeEn), 32'h0);
        chk("rst_addr", 32'(addrOut), 32'h0);
        chk("rst_data", 32'(dataOut), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_recording", 32'(recording), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        reset = 0;

        for (int v = 0; v < 7; v++)
            run_rec(vt[v].b, vt[v].l, vt[v].seed, vt[v].n, vt[v].same_stop, vt[v].gaps,
                    vt[v].exp_n, vt[v].exp_final, vt[v].exp_full);

        // Reset while the first sample is being written aborts without a header.
        wr0 = wr_q.size();
        dn0 = done_cnt;
        @(negedge clock);
        addrBase = 16'h0300; addrLimit = 16'h03FF; start = 1;
        @(negedge clock);
        start = 0; sampleValid = 1; sampleIn = 16'h5555;
        chk("abort_ready", 32'(ready), 32'h1);
        @(negedge clock);
        sampleValid = 0;
        chk("abort_in_write", {writeEn, 15'h0, addrOut}, {1'b1, 15'h0, 16'h0302});
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("abort_outputs", {27'h0, writeEn, ready, recording, done, full}, 32'h0);
        chk("abort_bus", {addrOut, dataOut}, 32'h0);
        repeat (5) @(negedge clock);
        chk("abort_writes", 32'(wr_q.size() - wr0), 32'h1);
        chk("abort_no_done", 32'(done_cnt - dn0), 32'h0);
        run_rec(16'h0300, 16'h03FF, 16'h7777, 2, 1'b0, 1'b0, 2, 16'h0303, 1'b0);

        // Randomized recordings: written count is min(offered, capacity).
        for (int r = 0; r < 20; r++) begin
            logic [15:0] b, l;
            int off, n, cap, w;
            b   = 16'($urandom_range(0, 16'hEFFF));
            off = int'($urandom_range(0, 12));
            l   = 16'(b + 16'(off));
            n   = int'($urandom_range(0, 9));
            cap = (off >= 2) ? off - 1 : 0;
            w   = (n < cap) ? n : cap;
            run_rec(b, l, 16'($urandom), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    w, 16'(b + 16'd1 + 16'(w)), n >= cap);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
